wired_mdu_wb_arb: RTL
=====================

// Module: wired_mdu_wb_arb
// PURPOSE
//   Writeback arbiter downstream of the MDU multiplier pipeline and the divider.
//   Buffers iq_mdu_resp_t results from both units in per-source FIFOs.
//   Merges them round-robin into one registered writeback stream for the ROB/CDB.
//   Backpressure goes to the units through mul_ready_o/div_ready_o. The multiplier
//   pipe stalls wholesale when mul_ready_o is low.
// PARAMETERS
//   DEPTH  2  entries per source FIFO; power of two, >=2; 2 sustains 1 result/cycle
// PORTS
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-high
//   flush_i      in   1      pipeline flush; drops all buffered results
//   mul_valid_i  in   1      multiplier result valid
//   mul_ready_o  out  1      arbiter can accept a multiplier result
//   mul_resp_i   in   $bits(iq_mdu_resp_t)  {wid, result[31:0]} from multiplier
//   div_valid_i  in   1      divider result valid
//   div_ready_o  out  1      arbiter can accept a divider result
//   div_resp_i   in   $bits(iq_mdu_resp_t)  {wid, result[31:0]} from divider
//   wb_valid_o   out  1      writeback result valid
//   wb_ready_i   in   1      writeback consumer accepts
//   wb_resp_o    out  $bits(iq_mdu_resp_t)  merged result
//   wb_src_o     out  1      source of wb_resp_o: 0=MUL, 1=DIV (debug/perf)
// BEHAVIOUR
//   - Reset/flush (same cycle effect; rst has priority):
//     - FIFO counts and pointers = 0; wb_valid_o = 0; rr_q = MUL.
//     - mul_ready_o = div_ready_o = 1 from the next cycle.
//     - Inputs presented in the flush cycle are dropped, not enqueued.
//   - Enqueue: x_valid_i && x_ready_o. x_ready_o = (cnt_x < DEPTH).
//     - Decoded from registered count only: full => ready=0 even with a same-cycle dequeue.
//     - No combinational path from wb_ready_i to x_ready_o.
//   - FIFO: wr/rd pointers of width $clog2(DEPTH) wrap naturally. cnt width $clog2(DEPTH+1).
//     Simultaneous enq+deq leaves cnt unchanged.
//   - Output register loads when (!wb_valid_o || wb_ready_i) and any FIFO is non-empty.
//     Otherwise the held value is unchanged while wb_valid_o && !wb_ready_i.
//     wb_valid_o clears on handshake with both FIFOs empty.
//   - Grant:
//     - Only one FIFO non-empty -> that source; rr_q unchanged.
//     - Both non-empty -> source rr_q; rr_q <= other source.
//   - Latency: result accepted at edge N (FIFO write) -> wb_valid_o high after edge N+1.
//     Throughput is 1 result/cycle with wb_ready_i=1.
//   - Ordering: per-source FIFO order preserved; no ordering guarantee across sources.
//   - wb_resp_o/wb_src_o are don't-care when wb_valid_o=0 and need no reset.
// STRUCTURE
//   - Package wired0_defines: iq_mdu_resp_t (existing).
//     Add localparams MDU_SRC_MUL=1'b0, MDU_SRC_DIV=1'b1.
//   - Sub-module wired_mdu_resp_fifo (DEPTH, payload iq_mdu_resp_t), instantiated twice.
//     Ports: push/full-ready, pop/empty, head data, flush.
//   - Top holds the rr_q bit, the grant logic and the output register.
// TESTING
//   1. Reset: rst=1 for 2 cycles -> wb_valid_o=0, mul_ready_o=div_ready_o=1 on first post-reset cycle.
//   2. Single mul result wid=5, result=32'h1234 at edge N, wb_ready_i=1 ->
//      wb_valid_o=1 after edge N+1 with wid=5, result=32'h1234, wb_src_o=0; deasserts next cycle.
//   3. Both sources push every cycle, 4 each, wb_ready_i=1 ->
//      output alternates MUL,DIV,MUL,DIV... (first MUL); 8 results in 8 consecutive cycles.
//   4. wb_ready_i=0, 3 mul pushes -> 2 accepted into the FIFO, one more held in the output
//      register, then mul_ready_o=0 with wb_resp_o stable. Release wb_ready_i=1 ->
//      results emerge in push order, no loss/duplication.
//   5. Flush with 2 buffered + 1 in the output register, and div_valid_i=1 in the same cycle ->
//      next cycle wb_valid_o=0, both readies=1. Nothing from before the flush ever appears.
//   6. Random valid/ready, 10k cycles, scoreboard per source (wid order, data match), with random flushes.

Source files
------------

// File: rtl/wired0_defines.sv
// Shared MDU response type and writeback source encodings.
package wired0_defines;

   localparam int WID_W = 5;

   typedef struct packed {
      logic [WID_W-1:0] wid;
      logic [31:0]      result;
   } iq_mdu_resp_t;

   localparam logic MDU_SRC_MUL = 1'b0;
   localparam logic MDU_SRC_DIV = 1'b1;

endpackage

// File: rtl/wired_mdu_resp_fifo.sv
// Per-source response FIFO; head visible combinationally, one-cycle write-to-head.
// push_ready decodes only the registered count, so a full FIFO refuses even during a pop.
module wired_mdu_resp_fifo
   import wired0_defines::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push_valid,
   output logic         push_ready,
   input  iq_mdu_resp_t push_data,
   input  logic         pop,
   output logic         empty,
   output iq_mdu_resp_t head_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   iq_mdu_resp_t   mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  cnt;
   logic           do_push;
   logic           do_pop;

   assign push_ready = (cnt < CW'(DEPTH));
   assign empty      = (cnt == '0);
   assign head_data  = mem[rd_ptr];
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked entirely by cnt.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wired_mdu_wb_arb.sv
// Round-robin merge of MUL/DIV results into one registered writeback stream.
// Accepted result reaches wb_valid_o one edge after its FIFO write; stalls hold the output.
module wired_mdu_wb_arb
   import wired0_defines::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         mul_valid_i,
   output logic         mul_ready_o,
   input  iq_mdu_resp_t mul_resp_i,
   input  logic         div_valid_i,
   output logic         div_ready_o,
   input  iq_mdu_resp_t div_resp_i,
   output logic         wb_valid_o,
   input  logic         wb_ready_i,
   output iq_mdu_resp_t wb_resp_o,
   output logic         wb_src_o
);

   logic         mul_empty;
   logic         div_empty;
   iq_mdu_resp_t mul_head;
   iq_mdu_resp_t div_head;
   logic         mul_pop;
   logic         div_pop;
   logic         load;
   logic         both;
   logic         sel;
   iq_mdu_resp_t sel_resp;
   logic         rr_q;

   wired_mdu_resp_fifo #(.DEPTH(DEPTH)) u_mul_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_i),
      .push_valid (mul_valid_i),
      .push_ready (mul_ready_o),
      .push_data  (mul_resp_i),
      .pop        (mul_pop),
      .empty      (mul_empty),
      .head_data  (mul_head)
   );

   wired_mdu_resp_fifo #(.DEPTH(DEPTH)) u_div_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_i),
      .push_valid (div_valid_i),
      .push_ready (div_ready_o),
      .push_data  (div_resp_i),
      .pop        (div_pop),
      .empty      (div_empty),
      .head_data  (div_head)
   );

   always_comb begin
      both     = !mul_empty && !div_empty;
      load     = (!wb_valid_o || wb_ready_i) && (!mul_empty || !div_empty);
      sel      = MDU_SRC_MUL;
      if (both)            sel = rr_q;
      else if (!div_empty) sel = MDU_SRC_DIV;
      mul_pop  = load && (sel == MDU_SRC_MUL);
      div_pop  = load && (sel == MDU_SRC_DIV);
      sel_resp = (sel == MDU_SRC_DIV) ? div_head : mul_head;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wb_valid_o <= 1'b0;
         rr_q       <= MDU_SRC_MUL;
      end else if (load) begin
         wb_valid_o <= 1'b1;
         // Pointer only advances when both sources actually competed.
         if (both) rr_q <= ~rr_q;
      end else if (wb_ready_i) begin
         wb_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load && !rst && !flush_i) begin
         wb_resp_o <= sel_resp;
         wb_src_o  <= sel;
      end
   end

endmodule
